// File: rtl/pa_xif_mem.sv
// rtl/pa_xif_mem.sv - shared types, constants and byte-lane helpers for the XIF memory responder
//
// Contents:
//   X_ID_WIDTH, XLEN      struct field widths used by every XIF struct
//   mem_size_e            access size encoding (byte / half / word)
//   EXC_*_MISALIGN        exception codes reported on mem_resp
//   x_mem_req_t, x_mem_resp_t, x_mem_result_t   CORE-V-XIF structs
//   mem_track_t           per-transaction record kept until the bus responds
//   f_is_legal, f_lane_be, f_lane_wdata, f_extract   lane alignment helpers

package pa_xif_mem;

  localparam int X_ID_WIDTH = 4;
  localparam int XLEN       = 32;
  localparam int XBYTES     = XLEN / 8;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  localparam logic [5:0] EXC_LD_MISALIGN = 6'd4;
  localparam logic [5:0] EXC_ST_MISALIGN = 6'd6;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [XLEN-1:0]       addr;
    logic [1:0]            mode;
    logic                  we;
    logic [2:0]            size;
    logic [XBYTES-1:0]     be;
    logic [1:0]            attr;
    logic [XLEN-1:0]       wdata;
    logic                  last;
    logic                  spec;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
    logic       dbg;
  } x_mem_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [XLEN-1:0]       rdata;
    logic                  err;
    logic                  dbg;
  } x_mem_result_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  we;
    logic [1:0]            offset;
    mem_size_e             size;
  } mem_track_t;

  // Sizes 3..7 are not defined and are treated like a misaligned access.
  function automatic logic f_is_legal(logic [2:0] size, logic [1:0] offset);
    case (size)
      3'd0:    return 1'b1;
      3'd1:    return !offset[0];
      3'd2:    return (offset == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Caller-supplied byte enables are relative to the access; move them onto bus lanes.
  function automatic logic [XBYTES-1:0] f_lane_be(logic [XBYTES-1:0] be, logic [1:0] offset,
                                                  mem_size_e size);
    logic [XBYTES-1:0]   mask;
    logic [2*XBYTES-1:0] shifted;
    case (size)
      SZ_BYTE: mask = 4'b0001;
      SZ_HALF: mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    shifted = {{XBYTES{1'b0}}, be & mask} << offset;
    return shifted[XBYTES-1:0];
  endfunction

  function automatic logic [XLEN-1:0] f_lane_wdata(logic [XLEN-1:0] wdata, mem_size_e size);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

  // Zero extension only; NaN-boxing for narrow FP loads happens in the coprocessor.
  function automatic logic [XLEN-1:0] f_extract(logic [XLEN-1:0] rdata, logic [1:0] offset,
                                                mem_size_e size);
    logic [XLEN-1:0] s;
    s = rdata >> {offset, 3'b000};
    case (size)
      SZ_BYTE: return {{(XLEN-8){1'b0}}, s[7:0]};
      SZ_HALF: return {{(XLEN-16){1'b0}}, s[15:0]};
      default: return s;
    endcase
  endfunction

endpackage

// File: rtl/xif_mem_track_fifo.sv
// rtl/xif_mem_track_fifo.sv - in-order tracking FIFO of granted bus transactions
//
// Ports:
//   i_ck, i_rst_n   clock, async active-low reset (clears pointers)
//   i_push, i_data  write one mem_track_t entry
//   i_pop, o_data   o_data is the oldest entry; i_pop retires it
//   o_full, o_empty occupancy flags
// A push while full is accepted when a pop happens in the same cycle.

module xif_mem_track_fifo
  import pa_xif_mem::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       i_ck,
  input  logic       i_rst_n,
  input  logic       i_push,
  input  mem_track_t i_data,
  input  logic       i_pop,
  output mem_track_t o_data,
  output logic       o_full,
  output logic       o_empty
);

  // A depth of one still gets a one-bit index so the pointer slices stay legal.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  mem_track_t      r_mem [0:(2**AW)-1];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   w_used;
  logic            w_do_push;
  logic            w_do_pop;

  assign w_used    = r_wr_ptr - r_rd_ptr;
  assign o_empty   = (w_used == '0);
  assign o_full    = (w_used == PW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_ck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_ck) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/xif_mem_responder.sv
// rtl/xif_mem_responder.sv - XIF memory request/result responder driving a pipelined req/gnt/rvalid bus
//
// Ports:
//   i_ck, i_rst_n                          clock, async active-low reset
//   i_mem_valid, o_mem_ready, i_mem_req    XIF memory request handshake
//   o_mem_resp                             exception info, same cycle as the handshake
//   o_mem_result_valid, o_mem_result       registered in-order result strobe
//   o_data_req, i_data_gnt                 bus request / grant
//   o_data_addr/we/be/wdata                bus address phase
//   i_data_rvalid, i_data_rdata, i_data_err   bus response phase (in order)

module xif_mem_responder
  import pa_xif_mem::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic              i_ck,
  input  logic              i_rst_n,
  input  logic              i_mem_valid,
  output logic              o_mem_ready,
  input  x_mem_req_t        i_mem_req,
  output x_mem_resp_t       o_mem_resp,
  output logic              o_mem_result_valid,
  output x_mem_result_t     o_mem_result,
  output logic              o_data_req,
  input  logic              i_data_gnt,
  output logic [XLEN-1:0]   o_data_addr,
  output logic              o_data_we,
  output logic [XBYTES-1:0] o_data_be,
  output logic [XLEN-1:0]   o_data_wdata,
  input  logic              i_data_rvalid,
  input  logic [XLEN-1:0]   i_data_rdata,
  input  logic              i_data_err
);

  logic          w_legal;
  logic          w_active;
  logic          w_room;
  logic          w_data_req;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  mem_size_e     w_size;
  mem_track_t    w_push_entry;
  mem_track_t    w_head;
  logic          r_result_valid;
  x_mem_result_t r_result;
  logic          r_proto_err;
  logic          w_unused;

  assign w_size   = mem_size_e'(i_mem_req.size[1:0]);
  assign w_legal  = f_is_legal(i_mem_req.size, i_mem_req.addr[1:0]);
  // Reset gates the combinational outputs so everything reads zero while rst is low.
  assign w_active = i_rst_n && i_mem_valid;
  // A response arriving while full retires the head this cycle, freeing a slot.
  assign w_room   = !w_fifo_full || i_data_rvalid;

  assign w_data_req  = w_active && w_legal && w_room;
  assign w_push      = w_data_req && i_data_gnt;
  assign w_pop       = i_data_rvalid && !w_fifo_empty;
  assign o_data_req  = w_data_req;
  assign o_mem_ready = w_push || (w_active && !w_legal && w_room);

  assign w_push_entry = '{id: i_mem_req.id, we: i_mem_req.we,
                          offset: i_mem_req.addr[1:0], size: w_size};

  always_comb begin
    o_mem_resp = '0;
    if (w_active && !w_legal && w_room) begin
      o_mem_resp.exc     = 1'b1;
      o_mem_resp.exccode = i_mem_req.we ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
    end
  end

  always_comb begin
    o_data_addr  = '0;
    o_data_we    = 1'b0;
    o_data_be    = '0;
    o_data_wdata = '0;
    if (w_data_req) begin
      o_data_addr  = {i_mem_req.addr[XLEN-1:2], 2'b00};
      o_data_we    = i_mem_req.we;
      o_data_be    = f_lane_be(i_mem_req.be, i_mem_req.addr[1:0], w_size);
      o_data_wdata = f_lane_wdata(i_mem_req.wdata, w_size);
    end
  end

  xif_mem_track_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_track_fifo (
    .i_ck    (i_ck),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // An rvalid with nothing outstanding (e.g. stale after reset) is dropped; the
  // sticky flag keeps a record of it for debug visibility.
  always_ff @(posedge i_ck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result_valid <= 1'b0;
      r_result       <= '0;
      r_proto_err    <= 1'b0;
    end else begin
      r_result_valid <= w_pop;
      if (w_pop) begin
        r_result.id    <= w_head.id;
        r_result.rdata <= w_head.we ? '0 : f_extract(i_data_rdata, w_head.offset, w_head.size);
        r_result.err   <= i_data_err;
        r_result.dbg   <= 1'b0;
      end
      if (i_data_rvalid && w_fifo_empty) r_proto_err <= 1'b1;
    end
  end

  assign o_mem_result_valid = r_result_valid;
  assign o_mem_result       = r_result;

  // Request attributes this responder does not act on (spec=1 is handled like spec=0).
  assign w_unused = ^{i_mem_req.mode, i_mem_req.attr, i_mem_req.last, i_mem_req.spec, r_proto_err};

endmodule
